// File: rtl/fp_narrow_cvt_pipe.sv
// Pipelined IEEE-754 narrowing converter (default FP64 -> FP16), RNE or RTZ per word.
// Latency: 3 cycles (S1 classify, S2 align, S3 round/pack); no bubble collapsing.
// Backpressure: one global enable; every stage holds while S3 is valid and out_ready is low.
// Optional: define FP_NARROW_CVT_FLAGS_EN to add out_flags = {invalid, overflow, underflow, inexact}.
module fp_narrow_cvt_pipe #(
    parameter int IN_EXP  = 11,
    parameter int IN_MAN  = 52,
    parameter int OUT_EXP = 5,
    parameter int OUT_MAN = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_EXP+IN_MAN:0]     in_data,
    input  logic                       in_rm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_EXP+OUT_MAN:0]   out_data
`ifdef FP_NARROW_CVT_FLAGS_EN
    ,
    output logic [3:0]                 out_flags
`endif
);

    localparam int EW        = IN_EXP + 2;
    localparam int NW        = OUT_EXP + OUT_MAN;
    localparam int XW        = IN_MAN + OUT_MAN + 3;
    localparam int SHW       = $clog2(OUT_MAN + 3);
    localparam int BIAS_DIFF = 2**(IN_EXP-1) - 2**(OUT_EXP-1);
    localparam int MAX_EXP   = 2**OUT_EXP - 2;

    localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS_DIFF);
    localparam logic signed [EW-1:0] E_ONE  = EW'(1);
    localparam logic signed [EW-1:0] E_MIN  = EW'(-OUT_MAN);
    localparam logic signed [EW-1:0] E_MAX  = EW'(MAX_EXP);
    // Shift that parks the hidden bit in the round position: everything left is sticky.
    localparam logic [SHW-1:0]       SH_SAT = SHW'(OUT_MAN + 2);
    localparam logic [NW-1:0]        INF_BODY = {{OUT_EXP{1'b1}}, {OUT_MAN{1'b0}}};
    localparam logic [NW-1:0]        MAX_BODY = {{(OUT_EXP-1){1'b1}}, 1'b0, {OUT_MAN{1'b1}}};

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- S1: classify / re-bias ----------------
    logic                 in_sign;
    logic [IN_EXP-1:0]    in_exp;
    logic [IN_MAN-1:0]    in_man;
    assign in_sign = in_data[IN_EXP+IN_MAN];
    assign in_exp  = in_data[IN_MAN +: IN_EXP];
    assign in_man  = in_data[IN_MAN-1:0];

    logic                 s1_vld, s1_sign, s1_nan, s1_inf, s1_zero, s1_rm;
    logic signed [EW-1:0] s1_e;
    logic [IN_MAN-1:0]    s1_man;
`ifdef FP_NARROW_CVT_FLAGS_EN
    logic                 s1_fnz;
`endif

    // Stage 1: unpack the wide word and move its exponent onto the narrow bias.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0; s1_sign <= 1'b0; s1_nan <= 1'b0; s1_inf <= 1'b0;
            s1_zero <= 1'b0; s1_rm <= 1'b0; s1_e <= '0; s1_man <= '0;
`ifdef FP_NARROW_CVT_FLAGS_EN
            s1_fnz <= 1'b0;
`endif
        end else if (adv) begin
            s1_vld  <= in_valid;
            s1_sign <= in_sign;
            s1_nan  <= (&in_exp) && (|in_man);
            s1_inf  <= (&in_exp) && !(|in_man);
            s1_zero <= !(|in_exp);
            s1_rm   <= in_rm;
            s1_e    <= $signed({2'b00, in_exp}) - E_BIAS;
            s1_man  <= in_man;
`ifdef FP_NARROW_CVT_FLAGS_EN
            s1_fnz  <= !(|in_exp) && (|in_man);
`endif
        end
    end

    // ---------------- S2: align into narrow mantissa + guard/round/sticky ----------------
    logic                 s1_normal, s1_ovf;
    logic signed [EW-1:0] s1_neg;
    logic [SHW-1:0]       s1_sh;
    logic [XW-1:0]        s1_ext;
    logic [NW-1:0]        s1_body, s1_spec_body;

    // Denormal targets shift {1,man} right by 1-e; very small values saturate the shift.
    always_comb begin
        s1_normal = (s1_e >= E_ONE);
        s1_ovf    = (s1_e > E_MAX);
        s1_neg    = E_ONE - s1_e;
        if (s1_normal)          s1_sh = '0;
        else if (s1_e >= E_MIN) s1_sh = s1_neg[SHW-1:0];
        else                    s1_sh = SH_SAT;
        s1_ext  = {1'b1, s1_man, {(OUT_MAN+2){1'b0}}} >> s1_sh;
        s1_body = {(s1_normal ? s1_e[OUT_EXP-1:0] : {OUT_EXP{1'b0}}), s1_ext[XW-2 -: OUT_MAN]};
        if (s1_nan)      s1_spec_body = {{OUT_EXP{1'b1}}, 1'b1, s1_man[IN_MAN-2 -: OUT_MAN-1]};
        else if (s1_inf) s1_spec_body = INF_BODY;
        else             s1_spec_body = '0;
    end

    logic              s2_vld, s2_sign, s2_rm, s2_spec, s2_ovf, s2_g, s2_r, s2_s;
    logic [NW-1:0]     s2_body, s2_spec_body;
`ifdef FP_NARROW_CVT_FLAGS_EN
    logic              s2_snan, s2_fnz;
`endif

    // Stage 2: register the truncated body, rounding bits and special-case override.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld <= 1'b0; s2_sign <= 1'b0; s2_rm <= 1'b0; s2_spec <= 1'b0; s2_ovf <= 1'b0;
            s2_g <= 1'b0; s2_r <= 1'b0; s2_s <= 1'b0; s2_body <= '0; s2_spec_body <= '0;
`ifdef FP_NARROW_CVT_FLAGS_EN
            s2_snan <= 1'b0; s2_fnz <= 1'b0;
`endif
        end else if (adv) begin
            s2_vld       <= s1_vld;
            s2_sign      <= s1_sign;
            s2_rm        <= s1_rm;
            s2_spec      <= s1_nan || s1_inf || s1_zero;
            s2_ovf       <= s1_ovf;
            s2_g         <= s1_ext[XW-2-OUT_MAN];
            s2_r         <= s1_ext[XW-3-OUT_MAN];
            s2_s         <= |s1_ext[XW-4-OUT_MAN:0];
            s2_body      <= s1_body;
            s2_spec_body <= s1_spec_body;
`ifdef FP_NARROW_CVT_FLAGS_EN
            s2_snan      <= s1_nan && !s1_man[IN_MAN-1];
            s2_fnz       <= s1_fnz;
`endif
        end
    end

    // ---------------- S3: round / pack ----------------
    logic          s2_inc, s2_cov, s2_ovf_any;
    logic [NW-1:0] s2_sum, s2_res;

    // Adding the increment to {exp,man} lets mantissa carry bump the exponent for free.
    always_comb begin
        s2_inc     = !s2_rm && s2_g && (s2_r || s2_s || s2_body[0]);
        s2_sum     = s2_body + NW'(s2_inc);
        s2_cov     = &s2_sum[NW-1 -: OUT_EXP];
        s2_ovf_any = s2_ovf || s2_cov;
        if (s2_spec)         s2_res = s2_spec_body;
        else if (s2_ovf_any) s2_res = s2_rm ? MAX_BODY : INF_BODY;
        else                 s2_res = s2_sum;
    end

`ifdef FP_NARROW_CVT_FLAGS_EN
    logic [3:0] s2_flags;
    logic       s2_nx, s2_tiny;
    // Flags follow the same rounding decision that produced the result.
    always_comb begin
        s2_nx    = s2_spec ? s2_fnz : (s2_g || s2_r || s2_s || s2_ovf_any);
        s2_tiny  = s2_spec ? s2_fnz : (!s2_ovf_any && !(|s2_sum[NW-1 -: OUT_EXP]));
        s2_flags = {s2_spec && s2_snan, !s2_spec && s2_ovf_any, s2_tiny && s2_nx, s2_nx};
    end
`endif

    // Stage 3: output register, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef FP_NARROW_CVT_FLAGS_EN
            out_flags <= '0;
`endif
        end else if (adv) begin
            out_valid <= s2_vld;
            out_data  <= {s2_sign, s2_res};
`ifdef FP_NARROW_CVT_FLAGS_EN
            out_flags <= s2_flags;
`endif
        end
    end

endmodule
